// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the write-back stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_DRAIN,
        WB_CALL,
        WB_RET
    } wb_state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] value;
        logic [3:0]  size;
    } pend_write_t;

    localparam logic [4:0] REG_A0 = 5'd10;

endpackage

// File: rtl/pend_write_fifo.sv
// pend_write_fifo: pending-store queue with wrap-bit pointers and zeroed head when empty.
module pend_write_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  pend_write_t din,
    output pend_write_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    pend_write_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) & (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // Stale storage must never leak onto the drain port.
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push & ~full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop & ~empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage with register write, store queue and ecall serialisation.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int PW_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEMWB_ready,
    input  logic        MEMWB_wbactive,
    input  logic [5:0]  memwb_rd,
    input  logic [63:0] memwb_aluresult,
    input  logic [63:0] memwb_loadeddata,
    input  logic        dataselect,
    input  logic        MEMWB_ecall,
    input  logic        MEMWB_pend_write,
    input  logic [3:0]  MEMWB_size,
    input  logic [63:0] MEMWB_value,
    input  logic [63:0] MEMWB_addr,
    output logic        WB_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [4:0]  WBEX_rd,
    output logic [63:0] WBEX_rdval,
    output logic        WBEX_wbactive,
    output logic        pw_valid,
    output logic [63:0] pw_addr,
    output logic [63:0] pw_value,
    output logic [3:0]  pw_size,
    input  logic        pw_ready,
    output logic        ecall_req,
    input  logic        ecall_ack,
    input  logic [63:0] ecall_a0
);

    wb_state_t   state;
    pend_write_t head;
    logic        acc, wr, full, empty;
    logic [63:0] wbval;
    logic        unused_rd_msb;

    assign unused_rd_msb = memwb_rd[5];
    assign WB_stall      = (state != WB_IDLE) | full;
    assign acc           = MEMWB_ready & ~WB_stall;
    assign wr            = acc & MEMWB_wbactive & (memwb_rd[4:0] != 5'd0);
    assign wbval         = dataselect ? memwb_loadeddata : memwb_aluresult;

    pend_write_fifo #(.DEPTH(PW_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (acc & MEMWB_pend_write),
        .pop   (pw_ready),
        .din   ('{addr: MEMWB_addr, value: MEMWB_value, size: MEMWB_size}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign pw_valid      = ~empty;
    assign pw_addr       = head.addr;
    assign pw_value      = head.value;
    assign pw_size       = head.size;
    assign WBEX_rd       = rf_waddr;
    assign WBEX_rdval    = rf_wdata;
    assign WBEX_wbactive = rf_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WB_IDLE;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            ecall_req <= 1'b0;
        end else begin
            rf_we <= wr;
            if (wr) begin
                rf_waddr <= memwb_rd[4:0];
                rf_wdata <= wbval;
            end
            case (state)
                WB_IDLE:  if (acc & MEMWB_ecall) state <= WB_DRAIN;
                WB_DRAIN: if (empty) begin
                    state     <= WB_CALL;
                    ecall_req <= 1'b1;
                end
                // The returned a0 goes straight into the write port for the RET cycle.
                WB_CALL:  if (ecall_ack) begin
                    state     <= WB_RET;
                    ecall_req <= 1'b0;
                    rf_we     <= 1'b1;
                    rf_waddr  <= REG_A0;
                    rf_wdata  <= ecall_a0;
                end
                default:  state <= WB_IDLE;
            endcase
        end
    end

endmodule
